// File: rtl/function_unit.sv
// RV32-style ALU: combinational result and ZCNV flags plus an EX/MEM output register.
// Optional macro FUNIT_FLUSH_EN adds a flush input that clears the register ahead of en.
module function_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FUNIT_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FS,
  input  logic             en,
  output logic [WIDTH-1:0] S,
  output logic [3:0]       ZCNVFlags,
  output logic [WIDTH-1:0] S_q,
  output logic [3:0]       ZCNVFlags_q
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [SHW-1:0]     shamt_s;
  logic [WIDTH-1:0]   res_s;
  logic               c_s;
  logic               v_s;
  logic [WIDTH-1:0]   s_q_r;
  logic [3:0]         flags_q_r;

  // Subtraction is formed as A + ~B + 1 so the carry-out doubles as the unsigned A >= B flag.
  assign add_s   = {1'b0, A} + {1'b0, B};
  assign sub_s   = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt_s = B[SHW-1:0];

  // Function decode, result and carry/overflow selection.
  always_comb begin
    res_s = {WIDTH{1'b0}};
    c_s   = 1'b0;
    v_s   = 1'b0;
    case (FS)
      4'b0000: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = sub_s[WIDTH];
        v_s   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0010: res_s = A << shamt_s;
      4'b0100: res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b0110: res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      4'b1000: res_s = A ^ B;
      4'b1010: res_s = A >> shamt_s;
      4'b1011: res_s = $unsigned($signed(A) >>> shamt_s);
      4'b1100: res_s = A | B;
      4'b1110: res_s = A & B;
      default: begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
      end
    endcase
  end

  assign S         = res_s;
  assign ZCNVFlags = {(res_s == {WIDTH{1'b0}}), c_s, res_s[WIDTH-1], v_s};

  // EX/MEM register: async clear, optional flush over load enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q_r     <= {WIDTH{1'b0}};
      flags_q_r <= 4'b0000;
    end
`ifdef FUNIT_FLUSH_EN
    else if (flush) begin
      s_q_r     <= {WIDTH{1'b0}};
      flags_q_r <= 4'b0000;
    end
`endif
    else if (en) begin
      s_q_r     <= S;
      flags_q_r <= ZCNVFlags;
    end else begin
      s_q_r     <= s_q_r;
      flags_q_r <= flags_q_r;
    end
  end

  assign S_q         = s_q_r;
  assign ZCNVFlags_q = flags_q_r;

endmodule

// File: tb/tb_function_unit.sv
// Directed self-checking bench for function_unit with hand-computed expectations.
module tb_function_unit;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  FS;
  logic        en;
  logic [31:0] S;
  logic [3:0]  ZCNVFlags;
  logic [31:0] S_q;
  logic [3:0]  ZCNVFlags_q;
`ifdef FUNIT_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int errors;

  function_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FUNIT_FLUSH_EN
    .flush(flush),
`endif
    .A(A),
    .B(B),
    .FS(FS),
    .en(en),
    .S(S),
    .ZCNVFlags(ZCNVFlags),
    .S_q(S_q),
    .ZCNVFlags_q(ZCNVFlags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] fs);
    A  = a;
    B  = b;
    FS = fs;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    en  = 1'b1;
    A   = 32'h0;
    B   = 32'h0;
    FS  = 4'b0000;
`ifdef FUNIT_FLUSH_EN
    flush = 1'b0;
`endif
    #2;
    check("reset_s_q", S_q, 32'h0);
    check("reset_flags_q", {28'h0, ZCNVFlags_q}, 32'h0);

    // Combinational path stays live in reset; register stays clear across an edge.
    alu(32'd5, 32'd5, 4'b0001);
    check("rst_comb_sub_s", S, 32'h0);
    check("rst_comb_sub_f", {28'h0, ZCNVFlags}, 32'hC);
    @(posedge clk); #1;
    check("rst_hold_s_q", S_q, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;

    alu(32'h7FFF_FFFF, 32'h1, 4'b0000);
    check("add_ovf_s", S, 32'h8000_0000);
    check("add_ovf_f", {28'h0, ZCNVFlags}, 32'h3);
    alu(32'hFFFF_FFFF, 32'h1, 4'b0000);
    check("add_carry_s", S, 32'h0);
    check("add_carry_f", {28'h0, ZCNVFlags}, 32'hC);
    alu(32'd5, 32'd5, 4'b0001);
    check("sub_eq_s", S, 32'h0);
    check("sub_eq_f", {28'h0, ZCNVFlags}, 32'hC);
    alu(32'd0, 32'd1, 4'b0001);
    check("sub_neg_s", S, 32'hFFFF_FFFF);
    check("sub_neg_f", {28'h0, ZCNVFlags}, 32'h2);
    alu(32'h8000_0000, 32'h1, 4'b0001);
    check("sub_ovf_s", S, 32'h7FFF_FFFF);
    check("sub_ovf_f", {28'h0, ZCNVFlags}, 32'h5);

    alu(32'h8000_0000, 32'h24, 4'b1011);
    check("sra_s", S, 32'hF800_0000);
    check("sra_f", {28'h0, ZCNVFlags}, 32'h2);
    alu(32'h8000_0000, 32'h24, 4'b1010);
    check("srl_s", S, 32'h0800_0000);
    alu(32'h8000_0000, 32'h24, 4'b0010);
    check("sll_s", S, 32'h0);
    check("sll_f", {28'h0, ZCNVFlags}, 32'h8);
    alu(32'h1234_5678, 32'h20, 4'b0010);
    check("sll_zero_s", S, 32'h1234_5678);
    alu(32'h0000_0001, 32'h0000_001F, 4'b0010);
    check("sll_31_s", S, 32'h8000_0000);

    alu(32'hFFFF_FFFF, 32'h1, 4'b0100);
    check("slt_s", S, 32'h1);
    check("slt_f", {28'h0, ZCNVFlags}, 32'h0);
    alu(32'hFFFF_FFFF, 32'h1, 4'b0110);
    check("sltu_s", S, 32'h0);
    check("sltu_f", {28'h0, ZCNVFlags}, 32'h8);

    alu(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1110);
    check("and_s", S, 32'hF000_F000);
    check("and_f", {28'h0, ZCNVFlags}, 32'h2);
    alu(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100);
    check("or_s", S, 32'hFFF0_FFF0);
    alu(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1000);
    check("xor_s", S, 32'h0FF0_0FF0);
    check("xor_f", {28'h0, ZCNVFlags}, 32'h0);

    alu(32'hFFFF_FFFF, 32'h1, 4'b0011);
    check("undef3_s", S, 32'h0);
    check("undef3_f", {28'h0, ZCNVFlags}, 32'h8);
    alu(32'h8000_0000, 32'h8000_0000, 4'b1111);
    check("undefF_f", {28'h0, ZCNVFlags}, 32'h8);

    // Register path: load, hold, async clear, resume.
    @(negedge clk);
    en = 1'b1;
    alu(32'd3, 32'd4, 4'b0000);
    @(posedge clk); #1;
    check("reg_load_s_q", S_q, 32'd7);
    check("reg_load_f_q", {28'h0, ZCNVFlags_q}, 32'h0);
    @(negedge clk);
    en = 1'b0;
    alu(32'hFFFF_FFFF, 32'h1, 4'b0000);
    @(posedge clk); #1;
    check("reg_hold_s_q", S_q, 32'd7);
    check("reg_hold_f_q", {28'h0, ZCNVFlags_q}, 32'h0);
    en = 1'b1;
    @(posedge clk); #1;
    check("reg_flags_q", {28'h0, ZCNVFlags_q}, 32'hC);

    @(negedge clk);
    alu(32'd3, 32'd4, 4'b0000);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_clr_s_q", S_q, 32'h0);
    check("async_clr_f_q", {28'h0, ZCNVFlags_q}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("resume_s_q", S_q, 32'd7);

`ifdef FUNIT_FLUSH_EN
    @(negedge clk);
    flush = 1'b1;
    alu(32'hFFFF_FFFF, 32'h1, 4'b0000);
    @(posedge clk); #1;
    check("flush_s_q", S_q, 32'h0);
    check("flush_f_q", {28'h0, ZCNVFlags_q}, 32'h0);
    flush = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/function_unit.md
FUNCTION_UNIT -- requirements
Module: function_unit

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; shift amount uses the low $clog2(WIDTH) bits of B (5 bits at 32).
REQ-002 clk  input  1  single clock; all registered outputs update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 A  input  WIDTH  operand A (rs1 or pc).
REQ-005 B  input  WIDTH  operand B (rs2, immediate or constant 4).
REQ-006 FS  input  4  function select, encoded {fun3, fun7bit}.
REQ-007 en  input  1  load enable for the registered outputs.
REQ-008 S  output  WIDTH  combinational result.
REQ-009 ZCNVFlags  output  4  combinational flags; bit3 Z, bit2 C, bit1 N, bit0 V.
REQ-010 S_q  output  WIDTH  registered copy of S (EX/MEM register).
REQ-011 ZCNVFlags_q  output  4  registered copy of ZCNVFlags.

Function
REQ-012 S and ZCNVFlags shall be purely combinational in A, B and FS, with zero-cycle latency.
REQ-013 FS decode: 0000 ADD A+B; 0001 SUB A-B; 0010 SLL A<<B[4:0]; 0100 SLT signed(A<B)?1:0; 0110 SLTU unsigned(A<B)?1:0; 1000 XOR; 1010 SRL logical A>>B[4:0]; 1011 SRA arithmetic A>>>B[4:0]; 1100 OR; 1110 AND.
REQ-014 Undefined FS codes (0011, 0101, 0111, 1001, 1101, 1111) shall give S=0, C=0, V=0 and Z/N per REQ-015.
REQ-015 Z=1 iff S==0; N=S[WIDTH-1]; both valid for every FS.
REQ-016 ADD: C = carry-out of A+B; V = 1 iff A and B have the same sign and S has the opposite sign.
REQ-017 SUB: computed as A+~B+1; C = carry-out of that sum (1 iff A>=B unsigned); V = 1 iff A and B have different signs and S's sign differs from A's.
REQ-018 All other operations: C=0, V=0.
REQ-019 Arithmetic wraps modulo 2^WIDTH; no saturation.
REQ-020 Shift amounts 0..31 are legal; shift by 0 returns A unchanged; B bits above [4:0] are ignored.
REQ-021 On a rising clk edge with en=1, S_q<=S and ZCNVFlags_q<=ZCNVFlags; with en=0, both hold.
REQ-022 Branch use: FS=0001 with Z/C/N/V supports BEQ/BNE (Z), BLT/BGE (N xor V) and BLTU/BGEU (C).

Reset
REQ-023 rst low shall immediately and asynchronously clear S_q and ZCNVFlags_q to 0, regardless of clk or en.
REQ-024 While rst is low, the registers shall stay 0; the combinational S and ZCNVFlags shall stay functional.
REQ-025 Registered updates shall resume on the first rising clk edge after rst deasserts.

Configuration
REQ-026 Macro FUNIT_FLUSH_EN: when defined, add input flush (1 bit).
REQ-027 With the macro, flush=1 at a rising edge shall load S_q=0 and ZCNVFlags_q=0, taking priority over en.
REQ-028 Without the macro, there is no flush port and REQ-021 alone governs the registers.

Verification
REQ-029 ADD: A=0x7FFFFFFF, B=1, FS=0000 -> S=0x80000000, ZCNVFlags=0011 (N=1, V=1).
REQ-030 SUB: A=5, B=5, FS=0001 -> S=0, ZCNVFlags=1100 (Z=1, C=1). SUB: A=0, B=1 -> S=0xFFFFFFFF, ZCNVFlags=0010 (C=0, N=1).
REQ-031 Shifts: A=0x80000000, B=0x24 -> SRA (1011) gives 0xF8000000, SRL (1010) gives 0x08000000, SLL (0010) gives 0.
REQ-032 Compares: A=0xFFFFFFFF, B=1 -> SLT gives 1, SLTU gives 0; AND/OR/XOR of 0xF0F0F0F0 and 0xFF00FF00 give 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
REQ-033 Register path: en=1, ADD 3+4 -> S_q=7 after one edge; en=0 with new operands -> S_q stays 7; rst pulsed low mid-cycle -> S_q=0 without a clock edge; with FUNIT_FLUSH_EN, flush=1 and en=1 -> S_q=0.
